// File: rtl/pipelined_cla_adder_pkg.sv
// Shared defaults, operation encoding and small helpers for the pipelined CLA adder.
// Combinational helpers only; no latency or backpressure of their own.
package pipelined_cla_adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_GROUP = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int num_stages(input int width, input int group);
        return width / group;
    endfunction

    // Subtraction is a + ~b + 1, so the injected carry replaces cin.
    function automatic logic carry_in(input op_e op, input logic cin);
        return (op == OP_SUB) ? 1'b1 : cin;
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA adder.
// slave = the adder, master = the stimulus/sink side driving operands and out_ready.
interface pipelined_cla_adder_if
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_cla_adder_cla_group.sv
// Combinational GROUP-bit carry-look-ahead slice with group propagate/generate outputs.
// Zero latency; no handshake.
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             c_in,
    output logic [GROUP-1:0] s,
    output logic             c_out,
    output logic             p,
    output logic             g
);
    logic [GROUP-1:0] pi;
    logic [GROUP-1:0] gi;
    logic [GROUP-1:0] gen;
    logic [GROUP-1:0] prop;
    logic [GROUP:0]   c;
    logic             term;

    // gen[i]/prop[i] are the prefix generate/propagate over bits 0..i, each a flat sum of products.
    always_comb begin
        pi   = a ^ b;
        gi   = a & b;
        gen  = '0;
        prop = '1;
        term = 1'b0;
        c    = '0;
        c[0] = c_in;
        for (int i = 0; i < GROUP; i++) begin
            for (int j = 0; j <= i; j++) begin
                term = gi[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & pi[k];
                end
                gen[i]  = gen[i] | term;
                prop[i] = prop[i] & pi[j];
            end
            c[i+1] = gen[i] | (prop[i] & c_in);
        end
        s     = pi ^ c[GROUP-1:0];
        c_out = c[GROUP];
        p     = prop[GROUP-1];
        g     = gen[GROUP-1];
    end
endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/sub: one GROUP-bit CLA slice per stage, carry and unused operand bits skewed through registers.
// Latency WIDTH/GROUP cycles, 1 op/cycle; whole pipe freezes while a result waits on out_ready (in_ready low).
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GROUP = DEF_GROUP
) (
    input logic                  clk,
    input logic                  rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int STAGES = num_stages(WIDTH, GROUP);
    localparam int LAST   = STAGES - 1;
    localparam int MSB    = WIDTH - 1;

    if (((WIDTH % GROUP) != 0) || (WIDTH < GROUP)) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH (%0d) must be a non-zero multiple of GROUP (%0d)", WIDTH, GROUP);
    end

    op_e              op;
    logic             adv;
    logic             c0;
    logic [WIDTH-1:0] bb0;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  bb_q  [STAGES];
    logic [WIDTH-1:0]  bb_d  [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];

    logic [WIDTH-1:0]  a_in   [STAGES];
    logic [WIDTH-1:0]  bb_in  [STAGES];
    logic [WIDTH-1:0]  sum_in [STAGES];
    logic [STAGES-1:0] stg_cin;

    logic [STAGES-1:0][GROUP-1:0] grp_s;
    logic [STAGES-1:0]            grp_c;
    logic [STAGES-1:0]            grp_p;
    logic [STAGES-1:0]            grp_g;

    assign op  = op_e'(bus.sub);
    assign bb0 = bus.b ^ {WIDTH{bus.sub}};
    assign c0  = carry_in(op, bus.cin);
    assign adv = !vld_q[LAST] || bus.out_ready;

    // Stage 0 works straight off the port; later stages off the previous stage's registers.
    always_comb begin
        a_in[0]    = bus.a;
        bb_in[0]   = bb0;
        sum_in[0]  = '0;
        stg_cin    = '0;
        stg_cin[0] = c0;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k]    = a_q[k-1];
            bb_in[k]   = bb_q[k-1];
            sum_in[k]  = sum_q[k-1];
            stg_cin[k] = c_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_group #(
            .GROUP (GROUP)
        ) u_cla (
            .a     (a_in[k][k*GROUP +: GROUP]),
            .b     (bb_in[k][k*GROUP +: GROUP]),
            .c_in  (stg_cin[k]),
            .s     (grp_s[k]),
            .c_out (grp_c[k]),
            .p     (grp_p[k]),
            .g     (grp_g[k])
        );

        a_group_carry: assert property (@(posedge clk) disable iff (rst)
            grp_c[k] == (grp_g[k] | (grp_p[k] & stg_cin[k])));
    end

    always_comb begin
        vld_d = vld_q;
        c_d   = c_q;
        a_d   = a_q;
        bb_d  = bb_q;
        sum_d = sum_q;
        if (adv) begin
            vld_d[0] = bus.in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                a_d[k]                     = a_in[k];
                bb_d[k]                    = bb_in[k];
                sum_d[k]                   = sum_in[k];
                sum_d[k][k*GROUP +: GROUP] = grp_s[k];
                c_d[k]                     = grp_c[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            c_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                bb_q[k]  <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            c_q   <= c_d;
            a_q   <= a_d;
            bb_q  <= bb_d;
            sum_q <= sum_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_q[LAST];
    assign bus.sum       = sum_q[LAST];
    assign bus.cout      = c_q[LAST];
    // Signed overflow: operands of equal sign producing a result of the other sign.
    assign bus.ovf       = (a_q[LAST][MSB] == bb_q[LAST][MSB]) && (sum_q[LAST][MSB] != a_q[LAST][MSB]);

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench: 16/4 and 8/4 adders driven each falling edge, expected results queued on accept
// and compared when the output handshake fires.
module tb_pipelined_cla_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(16)) bus16 ();
    pipelined_cla_adder_if #(.WIDTH(8))  bus8 ();

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
    pipelined_cla_adder #(.WIDTH(8),  .GROUP(4)) dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_out16, n_acc16, n_out8, n_acc8;
    string       cur_tag;
    logic [17:0] q16[$];
    logic [17:0] q8[$];
    bit          pin_vld = 1'b0;
    logic [17:0] pin_exp;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Returns {ovf, cout, sum} for a w-bit operation, sum zero-extended to 16 bits.
    function automatic logic [17:0] ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                                              input logic cin, input logic sub);
        logic [15:0] mask, aa, bb, s;
        logic [16:0] full;
        logic        co, ov;
        mask = 16'((32'd1 << w) - 1);
        aa   = a & mask;
        bb   = (sub ? ~b : b) & mask;
        full = {1'b0, aa} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
        s    = full[15:0] & mask;
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {ov, co, s};
    endfunction

    task automatic step16(input logic r, input logic iv, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic ordy);
        @(negedge clk);
        rst             = r;
        bus16.in_valid  = iv;
        bus16.a         = a;
        bus16.b         = b;
        bus16.cin       = cin;
        bus16.sub       = sub;
        bus16.out_ready = ordy;
        #1;
        if (!r) begin
            if (bus16.out_valid && ordy) begin
                n_out16++;
                if (q16.size() == 0) check({cur_tag, "_extra"}, 1, 0);
                else check({cur_tag, "_res"}, {14'd0, bus16.ovf, bus16.cout, bus16.sum}, {14'd0, q16.pop_front()});
            end
            if (iv && bus16.in_ready) begin
                n_acc16++;
                q16.push_back(pin_vld ? pin_exp : ref_model(16, a, b, cin, sub));
            end
        end
    endtask

    task automatic step8(input logic iv, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub, input logic ordy);
        @(negedge clk);
        bus8.in_valid  = iv;
        bus8.a         = a;
        bus8.b         = b;
        bus8.cin       = cin;
        bus8.sub       = sub;
        bus8.out_ready = ordy;
        #1;
        if (bus8.out_valid && ordy) begin
            n_out8++;
            if (q8.size() == 0) check("w8_extra", 1, 0);
            else check("w8_res", {14'd0, bus8.ovf, bus8.cout, 8'h00, bus8.sum}, {14'd0, q8.pop_front()});
        end
        if (iv && bus8.in_ready) begin
            n_acc8++;
            q8.push_back(ref_model(8, {8'h00, a}, {8'h00, b}, cin, sub));
        end
    endtask

    task automatic idle16(input logic ordy);
        step16(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, ordy);
    endtask

    task automatic send_pin16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                              input logic sub, input logic [17:0] exp);
        pin_vld = 1'b1;
        pin_exp = exp;
        step16(1'b0, 1'b1, a, b, cin, sub, 1'b1);
        pin_vld = 1'b0;
    endtask

    task automatic drain16();
        for (int i = 0; i < 20 && q16.size() != 0; i++) idle16(1'b1);
        check({cur_tag, "_drained"}, q16.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        logic [17:0] snap;
        logic [7:0]  corner [5];
        int          lat, irdy_low;

        corner = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
        {bus16.in_valid, bus16.a, bus16.b, bus16.cin, bus16.sub, bus16.out_ready} = '0;
        {bus8.in_valid, bus8.a, bus8.b, bus8.cin, bus8.sub, bus8.out_ready} = '0;
        n_out16 = 0; n_acc16 = 0; n_out8 = 0; n_acc8 = 0;

        // Reset held two cycles with operands offered throughout.
        cur_tag = "reset";
        step16(1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        step16(1'b1, 1'b1, 16'h1234, 16'h5678, 1'b1, 1'b0, 1'b0);
        check("rst_out_valid", bus16.out_valid, 0);
        check("rst_sum", bus16.sum, 0);
        check("rst_cout", bus16.cout, 0);
        check("rst_ovf", bus16.ovf, 0);
        idle16(1'b1);
        check("rst_in_ready", bus16.in_ready, 1);
        for (int i = 0; i < 5; i++) idle16(1'b1);

        // Directed add/sub corners, first one also measures latency.
        cur_tag = "directed";
        send_pin16(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            idle16(1'b1);
            if (bus16.out_valid) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, 4);
        send_pin16(16'h7FFF, 16'h0000, 1'b1, 1'b0, {1'b1, 1'b0, 16'h8000});
        send_pin16(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        send_pin16(16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        send_pin16(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        send_pin16(16'h0000, 16'h0000, 1'b0, 1'b1, {1'b0, 1'b1, 16'h0000});
        drain16();
        check("directed_cnt", n_out16, 6);

        // 20 back-to-back random ops.
        cur_tag  = "stream";
        n_out16  = 0;
        irdy_low = 0;
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            step16(1'b0, 1'b1, ra, rb, 1'($urandom), 1'($urandom), 1'b1);
            if (!bus16.in_ready) irdy_low++;
        end
        for (int i = 0; i < 4; i++) idle16(1'b1);
        check("stream_cnt", n_out16, 20);
        check("stream_in_ready_low", irdy_low, 0);
        check("stream_drained", q16.size(), 0);

        // Fill with out_ready low, then stall three cycles.
        cur_tag = "stall";
        n_acc16 = 0;
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            step16(1'b0, 1'b1, ra, rb, 1'($urandom), 1'($urandom), 1'b0);
        end
        check("fill_acc", n_acc16, 4);
        snap = {bus16.ovf, bus16.cout, bus16.sum};
        for (int i = 0; i < 3; i++) begin
            step16(1'b0, 1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b0);
            check("stall_in_ready", bus16.in_ready, 0);
            check("stall_out_valid", bus16.out_valid, 1);
            check("stall_hold", {14'd0, bus16.ovf, bus16.cout, bus16.sum}, {14'd0, snap});
        end
        check("stall_acc", n_acc16, 4);
        n_out16 = 0;
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            step16(1'b0, 1'b1, ra, rb, 1'($urandom), 1'($urandom), 1'b1);
        end
        drain16();
        check("release_cnt", n_out16, 8);

        // Reset in the middle of a stream discards everything in flight.
        cur_tag = "midrst";
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            step16(1'b0, 1'b1, ra, rb, 1'($urandom), 1'($urandom), 1'b1);
        end
        step16(1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
        q16.delete();
        idle16(1'b1);
        check("midrst_out_valid", bus16.out_valid, 0);
        check("midrst_sum", bus16.sum, 0);
        n_out16 = 0;
        for (int i = 0; i < 6; i++) idle16(1'b1);
        check("midrst_stale", n_out16, 0);

        // 8-bit instance: all corner combinations, then random ops with random backpressure.
        for (int ia = 0; ia < 5; ia++)
            for (int ib = 0; ib < 5; ib++)
                for (int m = 0; m < 4; m++)
                    step8(1'b1, corner[ia], corner[ib], 1'(m), 1'(m >> 1), 1'b1);
        for (int i = 0; i < 3000; i++)
            step8(1'($urandom_range(0, 7) != 0), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 20 && q8.size() != 0; i++) step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        check("w8_drained", q8.size(), 0);
        check("w8_cnt", n_out8, n_acc8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
